// File: rtl/proc_run_controller_if.sv
// Bundles the load stream, instruction-memory write port, core control and
// run status of proc_run_controller. master = host/bench, slave = controller.
interface proc_run_controller_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W:0]   init_len;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [DATA_W-1:0] imem_wdata;
    logic              proc_rst_n;
    logic              proc_en;
    logic [DATA_W-1:0] instr;
    logic [31:0]       pc;
    logic              restart;
    logic              halted;
    logic              timeout;
    logic [31:0]       halt_pc;
    logic [31:0]       cycle_count;

    modport master (
        output init_len, ld_valid, ld_data, instr, pc, restart,
        input  ld_ready, imem_we, imem_waddr, imem_wdata, proc_rst_n, proc_en,
               halted, timeout, halt_pc, cycle_count
    );

    modport slave (
        input  init_len, ld_valid, ld_data, instr, pc, restart,
        output ld_ready, imem_we, imem_waddr, imem_wdata, proc_rst_n, proc_en,
               halted, timeout, halt_pc, cycle_count
    );
endinterface

// File: rtl/proc_run_controller.sv
// Run controller for the single-cycle core: streams the program into
// instruction memory, releases the core, counts run cycles and freezes the
// core on HALT or on cycle-budget exhaustion. Every output is a flop.
module proc_run_controller #(
    parameter int                        ADDR_W     = 8,
    parameter int                        DATA_W     = 32,
    parameter int                        OPC_MSB    = 31,
    parameter int                        OPC_LSB    = 26,
    parameter logic [OPC_MSB-OPC_LSB:0]  HALT_OPC   = 6'h3F,
    parameter int unsigned               MAX_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    proc_run_controller_if.slave bus
);
    localparam int          CW    = ADDR_W + 1;
    // Full memory depth; longer load requests are cut to this so the write
    // address never wraps.
    localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [31:0]   LAST  = 32'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT, S_TIMEOUT} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, len_c;
    logic              rdy_q, rdy_d, we_q, we_d, prst_q, prst_d, pen_q, pen_d;
    logic              halted_q, halted_d, tmo_q, tmo_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [31:0]       hpc_q, hpc_d, ccnt_q, ccnt_d;
    logic              xfer, is_halt;

    assign len_c   = (bus.init_len > DEPTH) ? DEPTH : bus.init_len;
    assign xfer    = (state_q == S_LOAD) && bus.ld_valid && rdy_q;
    assign is_halt = (bus.instr[OPC_MSB:OPC_LSB] == HALT_OPC);

    // Next state and next value of every registered output.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdy_d    = 1'b0;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        prst_d   = prst_q;
        pen_d    = pen_q;
        halted_d = halted_q;
        tmo_d    = tmo_q;
        hpc_d    = hpc_q;
        ccnt_d   = ccnt_q;
        unique case (state_q)
            S_LOAD: begin
                prst_d = 1'b0;
                pen_d  = 1'b0;
                if (xfer) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q[ADDR_W-1:0];
                    wdata_d = bus.ld_data;
                    cnt_d   = cnt_q + CW'(1);
                end
                // Ready tracks the post-update count so it drops on the
                // same edge that accepts the last word.
                if (cnt_d < len_c) begin
                    rdy_d = 1'b1;
                end else if (!xfer) begin
                    state_d = S_RUN;
                    prst_d  = 1'b1;
                    pen_d   = 1'b1;
                end
            end
            S_RUN: begin
                ccnt_d = ccnt_q + 32'd1;
                if (is_halt) begin
                    state_d  = S_HALT;
                    hpc_d    = bus.pc;
                    halted_d = 1'b1;
                    pen_d    = 1'b0;
                end else if (ccnt_q == LAST) begin
                    state_d = S_TIMEOUT;
                    tmo_d   = 1'b1;
                    pen_d   = 1'b0;
                end
            end
            S_HALT, S_TIMEOUT: begin
                if (bus.restart) begin
                    state_d  = S_LOAD;
                    cnt_d    = '0;
                    ccnt_d   = '0;
                    halted_d = 1'b0;
                    tmo_d    = 1'b0;
                    hpc_d    = '0;
                    prst_d   = 1'b0;
                    pen_d    = 1'b0;
                end
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_LOAD;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            prst_q   <= 1'b0;
            pen_q    <= 1'b0;
            halted_q <= 1'b0;
            tmo_q    <= 1'b0;
            hpc_q    <= '0;
            ccnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            prst_q   <= prst_d;
            pen_q    <= pen_d;
            halted_q <= halted_d;
            tmo_q    <= tmo_d;
            hpc_q    <= hpc_d;
            ccnt_q   <= ccnt_d;
        end
    end

    assign bus.ld_ready    = rdy_q;
    assign bus.imem_we     = we_q;
    assign bus.imem_waddr  = waddr_q;
    assign bus.imem_wdata  = wdata_q;
    assign bus.proc_rst_n  = prst_q;
    assign bus.proc_en     = pen_q;
    assign bus.halted      = halted_q;
    assign bus.timeout     = tmo_q;
    assign bus.halt_pc     = hpc_q;
    assign bus.cycle_count = ccnt_q;
endmodule

// File: tb/tb_proc_run_controller.sv
// Bench for proc_run_controller: randomized load streams and programs checked
// against a transaction-level model of words accepted and run outcome.
module tb_proc_run_controller;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int MAXC   = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total  = 0;

    proc_run_controller_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

    proc_run_controller #(
        .ADDR_W(ADDR_W), .DATA_W(32), .OPC_MSB(31), .OPC_LSB(26),
        .HALT_OPC(6'h3F), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    // Load phase. Starts in the first LOAD cycle (ready still low) and ends
    // just after the edge that should enter RUN. pct<0 alternates valid.
    task automatic do_load(input int len, input int pct, input bit seq, input logic [31:0] dbase);
        int k = 0, eff, ncyc = 0, dut_wr = 0;
        bit rdy = 0, pend = 0, xfer, v, done = 0;
        logic [ADDR_W-1:0] pa = '0;
        logic [31:0] pd = '0, d;
        eff = (len > DEPTH) ? DEPTH : len;
        bus.init_len = len[ADDR_W:0];
        bus.instr    = 32'hFC00_0000;
        while (!done && ncyc < 4000) begin
            v = (pct < 0) ? (ncyc % 2 == 0) : ($urandom_range(0, 99) < pct);
            d = seq ? dbase + k : $urandom;
            bus.ld_valid = v;
            bus.ld_data  = d;
            bus.restart  = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (bus.imem_we === 1'b1) dut_wr++;
            total++; if (bus.ld_ready !== rdy) $display("FAIL ld_ready c%0d: got %b exp %b", ncyc, bus.ld_ready, rdy); else passed++;
            total++; if (bus.imem_we !== pend) $display("FAIL imem_we c%0d: got %b exp %b", ncyc, bus.imem_we, pend); else passed++;
            if (pend) begin
                total++; if (bus.imem_waddr !== pa) $display("FAIL imem_waddr: got %0d exp %0d", bus.imem_waddr, pa); else passed++;
                total++; if (bus.imem_wdata !== pd) $display("FAIL imem_wdata: got %h exp %h", bus.imem_wdata, pd); else passed++;
            end
            total++; if ({bus.proc_rst_n, bus.proc_en} !== 2'b00) $display("FAIL load_core_held: got %b exp 00", {bus.proc_rst_n, bus.proc_en}); else passed++;
            xfer = v && rdy;
            @(posedge clk); #1;
            ncyc++;
            pend = xfer;
            if (xfer) begin
                pa = k[ADDR_W-1:0];
                pd = d;
                k++;
            end
            done = (k == eff) && !xfer;
            rdy  = (k < eff);
        end
        bus.ld_valid = 1'b0;
        bus.restart  = 1'b0;
        total++; if (!done) $display("FAIL load_timeout: got %0d words exp %0d", k, eff); else passed++;
        total++; if (dut_wr !== eff) $display("FAIL write_count: got %0d exp %0d", dut_wr, eff); else passed++;
    endtask

    // Run phase from the first RUN cycle; halt_at = 1-based RUN cycle
    // carrying HALT (outside 1..MAXC means never), then checks freeze.
    task automatic do_run(input int halt_at, input bit zero_instr, input int restart_at, input logic [31:0] pc0);
        logic [31:0] ins, pcv, hpc = '0;
        int last;
        bit hit;
        hit  = (halt_at >= 1 && halt_at <= MAXC);
        last = hit ? halt_at : MAXC;
        for (int i = 1; i <= last; i++) begin
            ins = zero_instr ? 32'h0 : $urandom;
            if (ins[31:26] == 6'h3F) ins[31] = 1'b0;
            if (i == halt_at) ins[31:26] = 6'h3F;
            pcv = pc0 + 32'(4 * (i - 1));
            if (i == halt_at) hpc = pcv;
            bus.instr   = ins;
            bus.pc      = pcv;
            bus.restart = (i == restart_at);
            @(negedge clk);
            total++; if ({bus.proc_rst_n, bus.proc_en} !== 2'b11) $display("FAIL run_core_on c%0d: got %b exp 11", i, {bus.proc_rst_n, bus.proc_en}); else passed++;
            total++; if (bus.cycle_count !== 32'(i - 1)) $display("FAIL run_count c%0d: got %0d exp %0d", i, bus.cycle_count, i - 1); else passed++;
            total++; if ({bus.halted, bus.timeout, bus.ld_ready, bus.imem_we} !== 4'b0000) $display("FAIL run_flags c%0d: got %b exp 0000", i, {bus.halted, bus.timeout, bus.ld_ready, bus.imem_we}); else passed++;
            @(posedge clk); #1;
        end
        bus.restart = 1'b0;
        for (int j = 0; j < 3; j++) begin
            bus.instr = $urandom;
            bus.pc    = $urandom;
            @(negedge clk);
            total++; if (bus.halted !== hit) $display("FAIL halted: got %b exp %b", bus.halted, hit); else passed++;
            total++; if (bus.timeout !== !hit) $display("FAIL timeout: got %b exp %b", bus.timeout, !hit); else passed++;
            total++; if (bus.cycle_count !== 32'(last)) $display("FAIL final_count: got %0d exp %0d", bus.cycle_count, last); else passed++;
            total++; if (bus.halt_pc !== hpc) $display("FAIL halt_pc: got %h exp %h", bus.halt_pc, hpc); else passed++;
            total++; if (bus.proc_en !== 1'b0) $display("FAIL frozen_en: got %b exp 0", bus.proc_en); else passed++;
            if (hit) begin
                total++; if (bus.proc_rst_n !== 1'b1) $display("FAIL halt_rst_n: got %b exp 1", bus.proc_rst_n); else passed++;
            end
            @(posedge clk); #1;
        end
    endtask

    // Restart pulse from HALT/TIMEOUT; leaves the bench in the first LOAD cycle.
    task automatic test_restart();
        bus.restart = 1'b1;
        @(posedge clk); #1;
        bus.restart = 1'b0;
        total++; if ({bus.halted, bus.timeout, bus.proc_rst_n, bus.proc_en, bus.ld_ready} !== 5'b0) $display("FAIL restart_flags: got %b exp 00000", {bus.halted, bus.timeout, bus.proc_rst_n, bus.proc_en, bus.ld_ready}); else passed++;
        total++; if ({bus.halt_pc, bus.cycle_count} !== 64'h0) $display("FAIL restart_status: got %h exp 0", {bus.halt_pc, bus.cycle_count}); else passed++;
    endtask

    task automatic test_reset();
        bus.init_len = '0; bus.ld_valid = 1'b0; bus.ld_data = '0;
        bus.instr = '0; bus.pc = '0; bus.restart = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if ({bus.ld_ready, bus.imem_we, bus.proc_rst_n, bus.proc_en, bus.halted, bus.timeout} !== 6'b0) $display("FAIL reset_flags: got %b exp 000000", {bus.ld_ready, bus.imem_we, bus.proc_rst_n, bus.proc_en, bus.halted, bus.timeout}); else passed++;
        total++; if ({bus.imem_waddr, bus.imem_wdata, bus.halt_pc, bus.cycle_count} !== '0) $display("FAIL reset_values: got %h exp 0", {bus.imem_waddr, bus.imem_wdata, bus.halt_pc, bus.cycle_count}); else passed++;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_load_basic();
        do_load(4, 100, 1'b1, 32'hA0);
        do_run(10, 1'b1, 0, 32'h0);
        test_restart();
    endtask

    task automatic test_load_gaps();
        do_load(2, -1, 1'b0, 32'h0);
        do_run(0, 1'b0, 3, 32'h100);
        test_restart();
    endtask

    task automatic test_init_len_zero();
        do_load(0, 100, 1'b0, 32'h0);
        do_run(MAXC, 1'b0, 0, 32'h40);
        test_restart();
    endtask

    task automatic test_clamp();
        do_load(31, 100, 1'b1, 32'hC0);
        do_run(5, 1'b0, 0, 32'h200);
        test_restart();
    endtask

    task automatic test_reset_midload();
        bus.init_len = 5'd4; bus.ld_valid = 1'b1; bus.ld_data = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        total++; if ({bus.ld_ready, bus.imem_we, bus.imem_waddr, bus.imem_wdata} !== '0) $display("FAIL midload_reset: got %h exp 0", {bus.ld_ready, bus.imem_we, bus.imem_waddr, bus.imem_wdata}); else passed++;
        bus.ld_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        do_load(4, 100, 1'b1, 32'hB0);
        do_run(7, 1'b0, 0, 32'h0);
        test_restart();
    endtask

    task automatic test_reset_midrun();
        do_load(1, 100, 1'b0, 32'h0);
        bus.instr = 32'h0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        total++; if ({bus.proc_rst_n, bus.proc_en, bus.halted, bus.timeout} !== 4'b0) $display("FAIL midrun_reset_flags: got %b exp 0000", {bus.proc_rst_n, bus.proc_en, bus.halted, bus.timeout}); else passed++;
        total++; if (bus.cycle_count !== 32'h0) $display("FAIL midrun_reset_count: got %0d exp 0", bus.cycle_count); else passed++;
        @(posedge clk); #1;
        rst = 1'b1;
        do_load(3, 70, 1'b1, 32'hE0);
        do_run(0, 1'b0, 0, 32'h0);
        test_restart();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            do_load($urandom_range(0, 31), $urandom_range(30, 100), 1'b0, 32'h0);
            do_run($urandom_range(0, 20), 1'b0, $urandom_range(0, 16), $urandom & 32'hFFFF_FFFC);
            test_restart();
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_load_gaps();
        test_init_len_zero();
        test_clamp();
        test_reset_midload();
        test_reset_midrun();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/proc_run_controller.md
Name: proc_run_controller

Overview:
- Device-side counterpart to the simulation bench's clock/reset/finish driver.
- Owns the single-cycle processor's start-up and shut-down: loads instruction memory from a valid/ready word stream after reset, then releases the core and counts executed cycles.
- Detects the HALT opcode on the fetched instruction, freezes the core and reports halted (or timeout) so a bench or host can end the run.
- Sits between the load source, instruction memory write port and the processor's reset/enable inputs.

Parameters:
- ADDR_W, 8, instruction memory word-address width.
- DATA_W, 32, instruction word width.
- OPC_MSB, 31, opcode field MSB within instruction.
- OPC_LSB, 26, opcode field LSB.
- HALT_OPC, 6'h3F, opcode value meaning halt; width OPC_MSB-OPC_LSB+1.
- MAX_CYCLES, 1000, RUN cycles before timeout; must be ≥1, fits in 32 bits.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- init_len  in  ADDR_W+1  number of words to load; held stable while LOAD.
- ld_valid  in  1  load word available.
- ld_data  in  DATA_W  load word.
- ld_ready  out  1  controller accepts load word.
- imem_we  out  1  instruction memory write enable.
- imem_waddr  out  ADDR_W  write address.
- imem_wdata  out  DATA_W  write data.
- proc_rst_n  out  1  processor reset, active-low.
- proc_en  out  1  processor clock enable (PC/regfile update).
- instr  in  DATA_W  instruction currently fetched by processor.
- pc  in  32  processor PC.
- restart  in  1  single-cycle pulse: re-enter LOAD from HALT/TIMEOUT.
- halted  out  1  HALT executed.
- timeout  out  1  MAX_CYCLES elapsed without HALT.
- halt_pc  out  32  PC of HALT instruction.
- cycle_count  out  32  RUN cycles counted.

Behaviour:
- States: LOAD, RUN, HALT, TIMEOUT; state register on rst async clear.
- Reset (rst=0, any state, mid-load or mid-run): state=LOAD, word counter=0, ld_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, proc_rst_n=0, proc_en=0, halted=0, timeout=0, halt_pc=0, cycle_count=0.
- LOAD:
  - ld_ready=1 from the first clock after rst deasserts, while word counter < init_len.
  - Transfer occurs on a cycle with ld_valid && ld_ready.
  - imem_we/imem_waddr/imem_wdata are registered: a transfer at edge N drives imem_we=1, imem_waddr=counter, imem_wdata=ld_data for the cycle after edge N; counter++.
  - ld_valid low: no write, counter holds; no timeout in LOAD.
  - When counter==init_len with no write pending: ld_ready=0 and go to RUN next edge. init_len=0 → RUN after one LOAD cycle, no writes.
  - init_len > 2^ADDR_W: clamp to 2^ADDR_W; address never wraps.
  - proc_rst_n=0 and proc_en=0 throughout LOAD.
- RUN:
  - proc_rst_n=1, proc_en=1.
  - cycle_count increments by 1 each RUN cycle, including the HALT cycle.
  - instr[OPC_MSB:OPC_LSB]==HALT_OPC → next state HALT; capture halt_pc=pc.
  - Otherwise, if cycle_count reaches MAX_CYCLES-1 → next state TIMEOUT.
  - HALT and timeout on the same cycle → HALT wins.
- HALT: halted=1, proc_en=0, proc_rst_n=1; architectural state frozen; cycle_count, halt_pc hold.
- TIMEOUT: timeout=1, proc_en=0; cycle_count holds at MAX_CYCLES.
- restart:
  - In HALT or TIMEOUT: go to LOAD, clear counter, cycle_count, halted, timeout, halt_pc; proc_rst_n=0.
  - Ignored in LOAD and RUN.
- halted and timeout are never both 1.
- All outputs registered.

Test Plan:
- Reset then init_len=4, ld_valid held high with data 0xA0..0xA3 → four consecutive imem writes to addr 0..3 with matching data, ld_ready drops, proc_rst_n=1 next cycle.
- ld_valid toggled 1,0,1,0 during load of 2 words → writes only on valid cycles, addresses 0,1, counter stalls in gaps.
- init_len=0 → no imem_we, RUN entered one cycle after reset release.
- RUN, instr=0x00000000 for 9 cycles then 0xFC000000 at pc=0x24 → halted=1, halt_pc=0x24, cycle_count=10, proc_en=0; restart pulse → back to LOAD with all status cleared.
- MAX_CYCLES=16, never halt → timeout=1 after 16 RUN cycles, cycle_count=16, halted=0; HALT opcode on cycle 16 instead → halted=1, timeout=0.
- rst asserted mid-load (after 2 of 4 words) and mid-run → all outputs return to reset values immediately (asynchronously); reload restarts at address 0.
